// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops N-bit words from an upstream FIFO read port and packs K consecutive
//   words into one N*K-bit packet presented on a valid/ready port. A level
//   flush request emits whatever is assembled as a short packet so the
//   upstream FIFO can be drained at end of stream.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_empty   upstream FIFO empty
//   in_rdata   upstream FIFO read data (valid while in_empty=0)
//   in_re      upstream FIFO pop strobe
//   flush      level request to emit the current partial packet
//   out_valid  packet available
//   out_ready  downstream accepts the packet this cycle
//   out_data   packet, word i in bits [N*i+N-1:N*i]
//   out_count  number of valid words in out_data (1..K)
module fifo_word_packer #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_empty,
    input  logic [N-1:0]           in_rdata,
    output logic                   in_re,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*K-1:0]         out_data,
    output logic [$clog2(K+1)-1:0] out_count
);
    localparam int CNTW = $clog2(K);
    localparam int CW   = $clog2(K + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(K - 1);

    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [(K-1)*N-1:0] asm_q, asm_d;
    logic               out_valid_q, out_valid_d;
    logic [N*K-1:0]     out_data_q, out_data_d;
    logic [CW-1:0]      out_count_q, out_count_d;

    logic           out_free;
    logic           at_last;
    logic           pop;
    logic           flush_fire;
    logic           load;
    logic [N*K-1:0] pkt;

    always_comb begin
        out_free   = !out_valid_q || out_ready;
        at_last    = (cnt_q == CNT_LAST);
        // The last slot can only be filled when the output register can take
        // the completed packet in the same cycle.
        pop        = rst_n && !in_empty && (!at_last || out_free);
        flush_fire = flush && out_free && ((cnt_q != '0) || pop);
        load       = (pop && at_last) || flush_fire;

        // Unused assembly slots are always zero, so the popped word can simply
        // be dropped into slot cnt on top of the zero-padded buffer.
        pkt = {{N{1'b0}}, asm_q};
        if (pop) begin
            pkt[int'(cnt_q)*N +: N] = in_rdata;
        end

        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (load) begin
            out_data_d  = pkt;
            out_count_d = CW'(cnt_q) + CW'(pop);
            out_valid_d = 1'b1;
            cnt_d       = '0;
            asm_d       = '0;
        end else begin
            // load covers pop at the last slot, so cnt < K-1 here
            if (pop) begin
                asm_d[int'(cnt_q)*N +: N] = in_rdata;
                cnt_d = cnt_q + CNTW'(1);
            end
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_re     = pop;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: a queue-based packing model is
// compared against the DUT every cycle, plus literal expectations for the
// directed streaming, backpressure, flush and reset scenarios.
module tb_fifo_word_packer;
    localparam int N  = 32;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_empty  = 1'b1;
    logic [N-1:0]   in_rdata  = '0;
    logic           flush     = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_re;
    logic           out_valid;
    logic [N*K-1:0] out_data;
    logic [CW-1:0]  out_count;

    int checks   = 0;
    int failures = 0;

    fifo_word_packer #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_empty  (in_empty),
        .in_rdata  (in_rdata),
        .in_re     (in_re),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [N*K-1:0] act, input logic [N*K-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0]   m_asm[$];
    logic           m_valid = 1'b0;
    logic [N*K-1:0] m_data  = '0;
    int             m_count = 0;
    logic           m_pop;
    logic           m_free;
    logic [N*K-1:0] m_pkt;

    function automatic logic model_re();
        return rst_n && !in_empty && (m_asm.size() < K - 1 || !m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_asm.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_count = 0;
        end else begin
            m_pop  = model_re();
            m_free = !m_valid || out_ready;
            if (m_pop) m_asm.push_back(in_rdata);
            if (m_asm.size() == K || (flush && m_free && m_asm.size() > 0)) begin
                m_pkt = '0;
                foreach (m_asm[i]) m_pkt[i*N +: N] = m_asm[i];
                m_data  = m_pkt;
                m_count = m_asm.size();
                m_valid = 1'b1;
                m_asm.delete();
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst in_re", in_re, '0);
            check("rst out_valid", out_valid, '0);
            check("rst out_data", out_data, '0);
            check("rst out_count", out_count, '0);
        end else begin
            check("in_re", in_re, model_re());
            check("out_valid", out_valid, m_valid);
            check("out_data", out_data, m_data);
            check("out_count", out_count, m_count);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic e, input logic [N-1:0] d, input logic f, input logic r);
        @(posedge clk);
        #1;
        in_empty  = e;
        in_rdata  = d;
        flush     = f;
        out_ready = r;
    endtask

    localparam logic [N*K-1:0] PKT_1234 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [N*K-1:0] PKT_5678 = 128'h00000008_00000007_00000006_00000005;

    initial begin
        // reset with a non-empty FIFO: no pop allowed
        in_empty = 1'b0;
        in_rdata = 32'h55;
        repeat (2) @(negedge clk);
        check("reset in_re", in_re, '0);
        check("reset out_valid", out_valid, '0);
        check("reset out_data", out_data, '0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_empty = 1'b1;

        // streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, N'(i), 1'b0, 1'b1);
            @(negedge clk);
            check("stream in_re", in_re, 1);
            if (i == 4) check("stream latency valid", out_valid, 0);
            if (i == 5) begin
                check("stream pkt0 valid", out_valid, 1);
                check("stream pkt0 data", out_data, PKT_1234);
                check("stream pkt0 count", out_count, 4);
            end
        end
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("stream pkt1 valid", out_valid, 1);
        check("stream pkt1 data", out_data, PKT_5678);
        check("stream pkt1 count", out_count, 4);
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("stream idle valid", out_valid, 0);

        // backpressure
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, N'(i), 1'b0, 1'b0);
            @(negedge clk);
            check("bp in_re", in_re, 1);
            if (i >= 5) begin
                check("bp hold valid", out_valid, 1);
                check("bp hold data", out_data, PKT_1234);
            end
        end
        for (int j = 0; j < 2; j++) begin
            drive(1'b0, N'(8), 1'b0, 1'b0);
            @(negedge clk);
            check("bp stall in_re", in_re, 0);
            check("bp stall data", out_data, PKT_1234);
        end
        drive(1'b0, N'(8), 1'b0, 1'b1);
        @(negedge clk);
        check("bp release in_re", in_re, 1);
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("bp pkt1 valid", out_valid, 1);
        check("bp pkt1 data", out_data, PKT_5678);
        drive(1'b1, '0, 1'b0, 1'b1);

        // flush with partial data, FIFO empty
        drive(1'b0, N'(1), 1'b0, 1'b1);
        drive(1'b0, N'(2), 1'b0, 1'b1);
        drive(1'b1, '0, 1'b1, 1'b1);
        @(negedge clk);
        check("flush pre valid", out_valid, 0);
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("flush partial valid", out_valid, 1);
        check("flush partial data", out_data, 128'h00000000_00000000_00000002_00000001);
        check("flush partial count", out_count, 2);

        // flush coinciding with a pop
        drive(1'b0, N'('hA), 1'b0, 1'b1);
        drive(1'b0, N'('hB), 1'b1, 1'b1);
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("flush pop valid", out_valid, 1);
        check("flush pop data", out_data, 128'h00000000_00000000_0000000B_0000000A);
        check("flush pop count", out_count, 2);

        // flush with nothing assembled
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, '0, 1'b1, 1'b1);
            @(negedge clk);
            check("flush empty valid", out_valid, 0);
        end
        drive(1'b1, '0, 1'b0, 1'b1);

        // reset mid-packet with a held output packet
        for (int i = 1; i <= 6; i++) drive(1'b0, N'(i), 1'b0, 1'b0);
        drive(1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset valid", out_valid, 1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_empty = 1'b0;
        in_rdata = 32'h77;
        #1;
        check("mid reset in_re", in_re, '0);
        check("mid reset valid", out_valid, '0);
        check("mid reset data", out_data, '0);
        check("mid reset count", out_count, '0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_empty = 1'b1;
        for (int i = 1; i <= 4; i++) drive(1'b0, N'(i), 1'b0, 1'b1);
        drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("post reset valid", out_valid, 1);
        check("post reset data", out_data, PKT_1234);
        check("post reset count", out_count, 4);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 3, N'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6);
        end
        repeat (4) drive(1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer stage for the single-entry bypass FIFO and its siblings. It pops N-bit words from the FIFO's read side (`empty`/`re`/`rdata`) and packs K consecutive words into one N*K-bit packet. Packets are presented on a valid/ready output port. A flush request emits a partial packet early, so the FIFO can be drained at end of stream.

## Interface
- N, 32, word width; must match the upstream FIFO's N.
- K, 4, words per packet; K >= 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_empty  in  1  upstream FIFO `empty`.
- in_rdata  in  N  upstream FIFO `rdata`; valid whenever in_empty=0.
- in_re  out  N/A, 1 bit  upstream FIFO `re`; a pop occurs in each cycle it is 1.
- flush  in  1  level request to emit the current partial packet.
- out_valid  out  1  packet available.
- out_ready  in  1  downstream accepts the packet this cycle.
- out_data  out  N*K  packet; word 0 in bits [N-1:0], word i in bits [N*i+N-1:N*i].
- out_count  out  $clog2(K+1)  number of valid words in out_data (1..K).

## Operation
- State:
  - Assembly buffer asm[0..K-2] (N bits each).
  - Fill counter cnt, range 0..K-1.
  - Output register holding out_data, out_count and out_valid.
- Reset (rst_n=0): cnt=0, asm=0, out_valid=0, out_data=0, out_count=0. in_re is forced to 0 while rst_n=0.
- out_free = !out_valid || out_ready.
- Pop rule: in_re = rst_n && !in_empty && (cnt < K-1 || out_free). in_re does not depend on flush.
- Normal pop (in_re=1, cnt<K-1, no flush fire): asm[cnt] <= in_rdata; cnt <= cnt+1.
- Completion (in_re=1, cnt=K-1):
  - out_data <= {in_rdata, asm[K-2], ..., asm[0]}.
  - out_count <= K, out_valid <= 1.
  - cnt <= 0, asm cleared to 0.
- Flush fire: flush && out_free && (cnt>0 || in_re).
  - If a word is popped the same cycle, it is placed at slot cnt.
  - out_data <= asm words 0..cnt-1, then the popped word if any, with all higher slots 0.
  - out_count <= cnt + in_re, out_valid <= 1, cnt <= 0, asm cleared.
  - If cnt=K-1 and in_re=1, flush fire is identical to completion.
- Flush does not fire in these cases; the request is held pending and not recorded:
  - cnt=0 and no pop: nothing to emit.
  - Output register busy (!out_free).
- flush is level-sensitive. The requester holds it until it observes out_valid with out_count < K, or sees in_empty=1 with nothing assembled.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_count hold stable. No completion or flush fire can overwrite them.
- Handshake: when out_valid=1 and out_ready=1 with no new packet loaded, out_valid <= 0. When a new packet loads in the same cycle, out_valid stays 1 and the new data replaces the old.
- No pop occurs while in_empty=1, regardless of other inputs.

## Timing
- Pop is combinational from in_empty. With the bypass FIFO, a word enqueued in cycle t can be popped in cycle t.
- Latency: the K-th word is popped in cycle t; out_valid=1 with that packet from cycle t+1.
- Throughput: with out_ready held 1 and in_empty held 0, in_re=1 every cycle. One packet is emitted every K cycles.
- Backpressure: with out_valid=1 and out_ready=0, the block pops up to K-1 more words. in_re then drops to 0 at cnt=K-1 until out_ready=1.
- Reset mid-packet discards the assembled words and any unaccepted output packet. No word popped before reset is reissued.

## Test plan
- Streaming: N=32, K=4, push 1..8, out_ready=1.
  - Expect in_re=1 on every non-empty cycle.
  - Packet 0x00000004_00000003_00000002_00000001 with count 4, then packet 0x8_7_6_5 with count 4.
  - Each packet appears one cycle after its 4th pop.
- Backpressure: push 1..8 with out_ready=0.
  - Expect packet {4,3,2,1} valid and held stable.
  - Words 5, 6, 7 popped; in_re=0 with word 8 waiting.
  - Raise out_ready: word 8 popped that cycle, packet {8,7,6,5} valid the next cycle.
- Flush with partial data: push 1, 2, then hold flush=1 with the FIFO empty.
  - Expect out_data=0x0_0_2_1, out_count=2, then cnt=0.
- Flush coinciding with a pop: cnt=1 (word 0xA assembled), word 0xB arriving with flush=1.
  - Expect packet {0,0,0xB,0xA}, count 2, in the next cycle.
- Corner cases:
  - flush with cnt=0 and in_empty=1: no out_valid.
  - Reset asserted at cnt=2: all outputs 0 immediately.
  - After release, push 1..4 and expect {4,3,2,1} with no stale words.
